mux81_rr_arbiter: RTL and testbench
===================================

# mux81_rr_arbiter

Round-robin arbiter that shares the `mux81` 8:1 multiplexer between eight requesters. It drives the mux select `S[2:0]` from a registered grant, so one requester's input `I[n]` reaches `Y` at a time. Fairness is rotating-priority, and an optional hold-time limit prevents one requester from monopolising the mux. It sits directly in front of `mux81` as that block's select controller.

## Interface
- `MAX_HOLD`, default 4: maximum consecutive grant cycles per requester when the timeout feature is compiled in. Legal range 2..256.
- `clk`, input, 1: sole clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset, sampled on the rising edge of `clk`.
- `req`, input, 8: request vector; bit n means requester n wants `I[n]` routed to `Y`.
- `gnt`, output, 8: one-hot grant, registered, or all-zero.
- `sel`, output, 3: mux select, registered; connects to `mux81` `S`. Equals the index of the granted bit while `busy`=1.
- `busy`, output, 1: registered; high when any grant bit is set.

## Operation
- **State.**
  - FSM states: IDLE and GRANT.
  - `cur[2:0]`: current or last granted index.
  - `hold_cnt`: $clog2(MAX_HOLD) bits; present only with the macro.
- **Reset.** When `rst`=1 at an edge:
  - State goes to IDLE.
  - `gnt`=8'h00, `busy`=0, `sel`=3'd0, `hold_cnt`=0.
  - `cur`=3'd7, so requester 0 has top priority after reset.
  - Reset overrides all other activity, including mid-grant.
- **Priority search.** From index (cur+1) mod 8 upward with wrap-around, take the first n with `req[n]`=1. Search order for cur=5 is 6, 7, 0, 1, ..., 5.
- **IDLE.**
  - With `req`=0: stay in IDLE. `gnt`=0, `busy`=0, `sel` holds its last value.
  - With any `req` bit set: at the next edge go to GRANT. Set `cur`=n, `gnt`=1<<n, `sel`=n, `busy`=1, `hold_cnt`=0.
- **GRANT, `req[cur]`=1.** Hold the grant, subject to the timeout rule below.
- **GRANT, `req[cur]`=0 at an edge.** The grant is released at that edge.
  - If another request is pending, the search runs over `req` with bit cur masked. The grant moves directly to the winner with no idle cycle (back-to-back handover).
  - If no other request is pending, go to IDLE.
- **Request changes during a grant.** Requests that appear or drop while another requester is granted have no effect until the next arbitration point.
- **Grant-vector rules.** `gnt` is never multi-hot. `sel` never changes while `gnt` is unchanged.

## Timing
- Request to grant: 1 cycle. `req[n]` sampled at edge k gives `gnt[n]`=1 after edge k.
- Release to next grant: 1 cycle. `req[cur]`=0 sampled at edge k gives a new `gnt` (or 0) after edge k.
- `sel` and `gnt` update on the same edge, so `mux81` `Y` follows the new input within the combinational delay after that edge.
- All outputs are glitch-free registered signals. There is no combinational path from `req` to any output.

## Configuration
- Macro: `MUX81_ARB_TIMEOUT_EN`.
- **Defined:**
  - `hold_cnt` increments on each edge the grant is held, and resets to 0 on every new grant.
  - At an edge where `hold_cnt`==MAX_HOLD-1, `req[cur]`=1 and another request is pending, the grant preempts to the masked-search winner.
  - If no other request is pending, the grant holds and `hold_cnt` saturates at MAX_HOLD-1.
  - A requester therefore owns the mux for at most MAX_HOLD consecutive cycles while others wait.
- **Undefined:**
  - No `hold_cnt` register exists and `MAX_HOLD` is ignored.
  - A grant is held for as long as `req[cur]` stays high.

## Test plan
- **Reset, then single request.** `rst`=1 for 2 cycles, then `req`=8'h08. Expect `gnt`=8'h00, `sel`=0, `busy`=0 during reset. One cycle after the request, expect `gnt`=8'h08, `sel`=3, `busy`=1.
- **Post-reset priority.** `req`=8'hFF on the first post-reset edge. Expect `gnt`=8'h01 (requester 0 first). Drop `req[0]`; one cycle later expect `gnt`=8'h02 with no idle gap.
- **Wrap-around.** Grant 7 held with `req`=8'h81. Drop `req[7]`. Expect `gnt`=8'h01 and `sel`=0 next cycle.
- **Release to idle.** Single grant 2, then `req`=8'h00. Expect `gnt`=0 and `busy`=0 next cycle, with `sel` holding 2.
- **Timeout (macro defined, MAX_HOLD=4).** `req`=8'h05 continuously. Expect `gnt`=8'h01 for 4 cycles, then 8'h04 for 4 cycles, then 8'h01 again. With `req`=8'h01 only, `gnt` stays 8'h01 indefinitely. With the macro undefined and `req`=8'h05, `gnt` stays 8'h01 indefinitely.
- **Reset mid-grant.** Assert `rst` while `gnt`=8'h20. Expect `gnt`=0 and `sel`=0 after that edge. With `req`=8'h21 held, the first grant after reset is 8'h01.

Source files
------------

// File: rtl/mux81_rr_arbiter_if.sv
// Request/grant bundle between the eight requesters and the mux81 select arbiter.
// The slave modport is the arbiter side; the master modport is the requester side.
interface mux81_rr_arbiter_if;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       busy;

  modport slave  (input  req, output gnt, output sel, output busy);
  modport master (output req, input  gnt, input  sel, input  busy);
endinterface

// File: rtl/mux81_rr_arbiter.sv
// Rotating-priority arbiter that drives the mux81 select from a registered one-hot grant.
// Optional hold-time limit compiled in with `define MUX81_ARB_TIMEOUT_EN (uses MAX_HOLD).
module mux81_rr_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic                clk,
  input  logic                rst,
  mux81_rr_arbiter_if.slave   bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cur_q,   cur_d;
  logic [7:0]  gnt_q,   gnt_d;
  logic [2:0]  sel_q,   sel_d;
  logic        busy_q,  busy_d;

  logic [3:0]  pick_all;
  logic [3:0]  pick_oth;
  logic        take;
  logic [2:0]  take_idx;
  logic        go_idle;

`ifdef MUX81_ARB_TIMEOUT_EN
  localparam int               HOLD_W    = $clog2(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] hold_q, hold_d;
`endif

  // First set bit of r searching upward from last+1 with wrap; result is {found, index}.
  function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] last);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'b0000;
    for (int k = 1; k <= 8; k++) begin
      idx = last + 3'(k);
      res = (!res[3] && r[idx]) ? {1'b1, idx} : res;
    end
    return res;
  endfunction

  // Next-state and next-output logic for the IDLE/GRANT controller.
  always_comb begin
    pick_all = rr_pick(bus.req, cur_q);
    pick_oth = rr_pick(bus.req & ~(8'b0000_0001 << cur_q), cur_q);

    state_d  = state_q;
    cur_d    = cur_q;
    gnt_d    = gnt_q;
    sel_d    = sel_q;
    busy_d   = busy_q;
    take     = 1'b0;
    take_idx = 3'd0;
    go_idle  = 1'b0;
`ifdef MUX81_ARB_TIMEOUT_EN
    hold_d   = hold_q;
`endif

    case (state_q)
      IDLE: begin
        if (pick_all[3]) begin
          take     = 1'b1;
          take_idx = pick_all[2:0];
        end else begin
          go_idle  = 1'b1;
        end
      end
      GRANT: begin
        if (!bus.req[cur_q]) begin
          // Owner released: hand straight over to the masked winner, else fall idle.
          if (pick_oth[3]) begin
            take     = 1'b1;
            take_idx = pick_oth[2:0];
          end else begin
            go_idle  = 1'b1;
          end
        end else begin
`ifdef MUX81_ARB_TIMEOUT_EN
          if ((hold_q == HOLD_LAST) && pick_oth[3]) begin
            take     = 1'b1;
            take_idx = pick_oth[2:0];
          end else if (hold_q != HOLD_LAST) begin
            hold_d   = hold_q + {{(HOLD_W-1){1'b0}}, 1'b1};
          end else begin
            hold_d   = hold_q;
          end
`else
          take = 1'b0;
`endif
        end
      end
      default: begin
        go_idle = 1'b1;
      end
    endcase

    if (take) begin
      state_d = GRANT;
      cur_d   = take_idx;
      gnt_d   = 8'b0000_0001 << take_idx;
      sel_d   = take_idx;
      busy_d  = 1'b1;
`ifdef MUX81_ARB_TIMEOUT_EN
      hold_d  = {HOLD_W{1'b0}};
`endif
    end else if (go_idle) begin
      // sel deliberately keeps its last value so mux81 Y does not move while idle.
      state_d = IDLE;
      gnt_d   = 8'h00;
      busy_d  = 1'b0;
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cur_q   <= 3'd7;
      gnt_q   <= 8'h00;
      sel_q   <= 3'd0;
      busy_q  <= 1'b0;
`ifdef MUX81_ARB_TIMEOUT_EN
      hold_q  <= {HOLD_W{1'b0}};
`endif
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
`ifdef MUX81_ARB_TIMEOUT_EN
      hold_q  <= hold_d;
`endif
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.sel  = sel_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_mux81_rr_arbiter.sv
// Scoreboard bench for mux81_rr_arbiter: expectations queued at drive time, popped after each edge.
module tb_mux81_rr_arbiter;

  localparam int MH = 4;

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
  } exp_t;

  typedef struct packed {
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t sb[$];

  // reference model state for the random run
  logic       m_busy;
  logic [2:0] m_cur;
  logic [7:0] m_gnt;
  logic [2:0] m_sel;
  int         m_hold;

  mux81_rr_arbiter_if bus_if ();

  mux81_rr_arbiter #(.MAX_HOLD(MH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic r_rst, input logic [7:0] r_req, input exp_t e);
    @(negedge clk);
    rst        = r_rst;
    bus_if.req = r_req;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    vec_t tv [3] = '{
      '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0},
      '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0},
      '{1'b0, 8'h08, 8'h08, 3'd3, 1'b1}
    };
    exp_t e;
    foreach (tv[i]) begin
      drive(tv[i].rst, tv[i].req, '{tv[i].gnt, tv[i].sel, tv[i].busy});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({bus_if.gnt, bus_if.sel, bus_if.busy} !== {e.gnt, e.sel, e.busy}) begin
        errors++;
        $display("FAIL reset[%0d]: gnt=%h sel=%0d busy=%b want gnt=%h sel=%0d busy=%b",
                 i, bus_if.gnt, bus_if.sel, bus_if.busy, e.gnt, e.sel, e.busy);
      end
    end
  endtask

  task automatic test_priority();
    vec_t tv [4] = '{
      '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0},
      '{1'b0, 8'hFF, 8'h01, 3'd0, 1'b1},
      '{1'b0, 8'hFE, 8'h02, 3'd1, 1'b1},
      '{1'b0, 8'hFC, 8'h04, 3'd2, 1'b1}
    };
    exp_t e;
    foreach (tv[i]) begin
      drive(tv[i].rst, tv[i].req, '{tv[i].gnt, tv[i].sel, tv[i].busy});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({bus_if.gnt, bus_if.sel, bus_if.busy} !== {e.gnt, e.sel, e.busy}) begin
        errors++;
        $display("FAIL priority[%0d]: gnt=%h sel=%0d busy=%b want gnt=%h sel=%0d busy=%b",
                 i, bus_if.gnt, bus_if.sel, bus_if.busy, e.gnt, e.sel, e.busy);
      end
    end
  endtask

  task automatic test_wrap();
    vec_t tv [4] = '{
      '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0},
      '{1'b0, 8'h80, 8'h80, 3'd7, 1'b1},
      '{1'b0, 8'h81, 8'h80, 3'd7, 1'b1},
      '{1'b0, 8'h01, 8'h01, 3'd0, 1'b1}
    };
    exp_t e;
    foreach (tv[i]) begin
      drive(tv[i].rst, tv[i].req, '{tv[i].gnt, tv[i].sel, tv[i].busy});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({bus_if.gnt, bus_if.sel, bus_if.busy} !== {e.gnt, e.sel, e.busy}) begin
        errors++;
        $display("FAIL wrap[%0d]: gnt=%h sel=%0d busy=%b want gnt=%h sel=%0d busy=%b",
                 i, bus_if.gnt, bus_if.sel, bus_if.busy, e.gnt, e.sel, e.busy);
      end
    end
  endtask

  task automatic test_release_idle();
    vec_t tv [5] = '{
      '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0},
      '{1'b0, 8'h04, 8'h04, 3'd2, 1'b1},
      '{1'b0, 8'h00, 8'h00, 3'd2, 1'b0},
      '{1'b0, 8'h00, 8'h00, 3'd2, 1'b0},
      '{1'b0, 8'h10, 8'h10, 3'd4, 1'b1}
    };
    exp_t e;
    foreach (tv[i]) begin
      drive(tv[i].rst, tv[i].req, '{tv[i].gnt, tv[i].sel, tv[i].busy});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({bus_if.gnt, bus_if.sel, bus_if.busy} !== {e.gnt, e.sel, e.busy}) begin
        errors++;
        $display("FAIL release_idle[%0d]: gnt=%h sel=%0d busy=%b want gnt=%h sel=%0d busy=%b",
                 i, bus_if.gnt, bus_if.sel, bus_if.busy, e.gnt, e.sel, e.busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t tv [6] = '{
      '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0},
      '{1'b0, 8'h04, 8'h04, 3'd2, 1'b1},
      '{1'b0, 8'h0C, 8'h04, 3'd2, 1'b1},
      '{1'b0, 8'h08, 8'h08, 3'd3, 1'b1},
      '{1'b0, 8'h0A, 8'h08, 3'd3, 1'b1},
      '{1'b0, 8'h02, 8'h02, 3'd1, 1'b1}
    };
    exp_t e;
    foreach (tv[i]) begin
      drive(tv[i].rst, tv[i].req, '{tv[i].gnt, tv[i].sel, tv[i].busy});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({bus_if.gnt, bus_if.sel, bus_if.busy} !== {e.gnt, e.sel, e.busy}) begin
        errors++;
        $display("FAIL back_to_back[%0d]: gnt=%h sel=%0d busy=%b want gnt=%h sel=%0d busy=%b",
                 i, bus_if.gnt, bus_if.sel, bus_if.busy, e.gnt, e.sel, e.busy);
      end
    end
  endtask

  task automatic test_reset_mid_grant();
    vec_t tv [4] = '{
      '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0},
      '{1'b0, 8'h20, 8'h20, 3'd5, 1'b1},
      '{1'b1, 8'h21, 8'h00, 3'd0, 1'b0},
      '{1'b0, 8'h21, 8'h01, 3'd0, 1'b1}
    };
    exp_t e;
    foreach (tv[i]) begin
      drive(tv[i].rst, tv[i].req, '{tv[i].gnt, tv[i].sel, tv[i].busy});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({bus_if.gnt, bus_if.sel, bus_if.busy} !== {e.gnt, e.sel, e.busy}) begin
        errors++;
        $display("FAIL reset_mid[%0d]: gnt=%h sel=%0d busy=%b want gnt=%h sel=%0d busy=%b",
                 i, bus_if.gnt, bus_if.sel, bus_if.busy, e.gnt, e.sel, e.busy);
      end
    end
  endtask

  task automatic test_hold_limit();
    exp_t e;
    logic [7:0] r;
    int          owner;
    for (int i = 0; i < 23; i++) begin
      if (i == 0 || i == 13) begin
        drive(1'b1, 8'h00, '{8'h00, 3'd0, 1'b0});
      end else begin
        r     = (i < 13) ? 8'h05 : 8'h01;
        owner = 0;
`ifdef MUX81_ARB_TIMEOUT_EN
        if (i < 13) owner = (((i - 1) / MH) % 2 == 0) ? 0 : 2;
`endif
        drive(1'b0, r, '{8'h01 << owner, 3'(owner), 1'b1});
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({bus_if.gnt, bus_if.sel, bus_if.busy} !== {e.gnt, e.sel, e.busy}) begin
        errors++;
        $display("FAIL hold_limit[%0d]: gnt=%h sel=%0d busy=%b want gnt=%h sel=%0d busy=%b",
                 i, bus_if.gnt, bus_if.sel, bus_if.busy, e.gnt, e.sel, e.busy);
      end
    end
  endtask

  // Behavioural model of one clock edge; returns the expected outputs after that edge.
  task automatic model_step(input logic r_rst, input logic [7:0] r, output exp_t e);
    logic [7:0] cand;
    logic       rearb;
    int         idx;
    logic       found;
    if (r_rst) begin
      m_busy = 1'b0; m_cur = 3'd7; m_gnt = 8'h00; m_sel = 3'd0; m_hold = 0;
    end else begin
      rearb = 1'b0;
      cand  = r;
      if (!m_busy) begin
        rearb = 1'b1;
      end else if (!r[m_cur]) begin
        rearb = 1'b1;
        cand  = r & ~(8'h01 << m_cur);
      end else begin
`ifdef MUX81_ARB_TIMEOUT_EN
        if (m_hold == MH - 1 && (r & ~(8'h01 << m_cur)) != 8'h00) begin
          rearb = 1'b1;
          cand  = r & ~(8'h01 << m_cur);
        end else if (m_hold < MH - 1) begin
          m_hold++;
        end
`endif
      end
      if (rearb) begin
        found = 1'b0;
        for (int k = 1; k <= 8; k++) begin
          idx = (int'(m_cur) + k) % 8;
          if (!found && cand[idx]) begin
            found  = 1'b1;
            m_cur  = 3'(idx);
            m_gnt  = 8'h01 << idx;
            m_sel  = 3'(idx);
            m_busy = 1'b1;
            m_hold = 0;
          end
        end
        if (!found) begin
          m_busy = 1'b0;
          m_gnt  = 8'h00;
        end
      end
    end
    e = '{m_gnt, m_sel, m_busy};
  endtask

  task automatic test_random();
    exp_t       e;
    logic [7:0] r;
    logic       rs;
    r = 8'h00;
    for (int i = 0; i < 400; i++) begin
      rs = (i == 0) || ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 99) < 35) r = 8'($urandom_range(0, 255));
      model_step(rs, r, e);
      drive(rs, r, e);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({bus_if.gnt, bus_if.sel, bus_if.busy} !== {e.gnt, e.sel, e.busy}) begin
        errors++;
        $display("FAIL random[%0d] req=%h: gnt=%h sel=%0d busy=%b want gnt=%h sel=%0d busy=%b",
                 i, r, bus_if.gnt, bus_if.sel, bus_if.busy, e.gnt, e.sel, e.busy);
      end
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    bus_if.req = 8'h00;
    test_reset();
    test_priority();
    test_wrap();
    test_release_idle();
    test_back_to_back();
    test_reset_mid_grant();
    test_hold_limit();
    test_random();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: left=%0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
